// File: rtl/pc_ras_pkg.sv
// Shared constants for the PC sequencer and return-address stack.
package pc_ras_pkg;
  localparam logic [31:0] PC_RAS_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_RAS_EXC_VEC   = 32'h8000_0180;
  localparam int          PC_RAS_CNT_W     = 16;
endpackage

// File: rtl/pc_ras_if.sv
// Control and status bundle between the fetch stage and pc_ras.
interface pc_ras_if #(
  parameter int AW = 32
);
  import pc_ras_pkg::*;

  logic                    stall;
  logic                    exc;
  logic [AW-1:0]           br_offset;
  logic [25:0]             jidx;
  logic [AW-1:0]           jr_target;
  logic                    jump;
  logic                    link;
  logic                    branch;
  logic                    jump_reg;
  logic                    ret;
  logic [AW-1:0]           pc;
  logic [AW-1:0]           pc_plus_8;
  logic [AW-1:0]           ras_top;
  logic                    ras_valid;
  logic                    ras_mispredict;
  logic [PC_RAS_CNT_W-1:0] mispredict_cnt;

  modport master (
    output stall, exc, br_offset, jidx, jr_target, jump, link, branch, jump_reg, ret,
    input  pc, pc_plus_8, ras_top, ras_valid, ras_mispredict, mispredict_cnt
  );

  modport slave (
    input  stall, exc, br_offset, jidx, jr_target, jump, link, branch, jump_reg, ret,
    output pc, pc_plus_8, ras_top, ras_valid, ras_mispredict, mispredict_cnt
  );
endinterface

// File: rtl/pc_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
  parameter int AW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          valid
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [OW-1:0] occ;
  logic [PW-1:0] top_ptr;

  // wr_ptr is the next free slot, so the top entry sits one below it
  assign top_ptr = wr_ptr - 1'b1;
  assign top     = mem[top_ptr];
  assign valid   = (occ != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      occ    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (occ != OW'(DEPTH)) occ <= occ + 1'b1;
    end else if (pop && valid) begin
      wr_ptr <= top_ptr;
      occ    <= occ - 1'b1;
    end
  end
endmodule

// File: rtl/pc_ras.sv
// Program counter with next-PC selection, return-address prediction and mispredict counter.
module pc_ras
  import pc_ras_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int          DEPTH     = 4,
  parameter logic [AW-1:0] RESET_VEC = AW'(PC_RAS_RESET_VEC),
  parameter logic [AW-1:0] EXC_VEC   = AW'(PC_RAS_EXC_VEC)
) (
  input logic     clk,
  input logic     rst,
  pc_ras_if.slave bus
);
  logic [AW-1:0]           pc_q;
  logic [AW-1:0]           pc_next;
  logic [AW-1:0]           pc_plus_4;
  logic                    push;
  logic                    pop;
  logic                    mismatch;
  logic [AW-1:0]           top;
  logic                    valid;
  logic                    mispredict_q;
  logic [PC_RAS_CNT_W-1:0] cnt_q;

  assign pc_plus_4 = pc_q + AW'(4);

  always_comb begin
    pc_next = pc_plus_4;
    push    = 1'b0;
    pop     = 1'b0;
    if (bus.exc) begin
      pc_next = EXC_VEC;
    end else if (bus.stall) begin
      pc_next = pc_q;
    end else if (bus.jump) begin
      pc_next = {pc_plus_4[AW-1:28], bus.jidx, 2'b00};
      push    = bus.link;
    end else if (bus.branch) begin
      pc_next = pc_plus_4 + bus.br_offset;
    end else if (bus.jump_reg) begin
      pc_next = bus.jr_target;
      pop     = bus.ret & valid;
    end
  end

  assign mismatch = pop && (top != bus.jr_target);

  ras_stack #(.AW(AW), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data (bus.pc_plus_8),
    .top       (top),
    .valid     (valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      mispredict_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      pc_q         <= pc_next;
      mispredict_q <= mismatch;
      if (mismatch && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.pc_plus_8      = pc_q + AW'(8);
  assign bus.ras_top        = top;
  assign bus.ras_valid      = valid;
  assign bus.ras_mispredict = mispredict_q;
  assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_pc_ras.sv
// Directed bench for pc_ras: sequencing, JAL/JR return prediction, stall/exception, async reset.
module tb_pc_ras;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pc_ras_if #(.AW(32)) bus ();

  pc_ras #(.AW(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.exc = 0; bus.br_offset = 0; bus.jidx = 0; bus.jr_target = 0;
    bus.jump = 0; bus.link = 0; bus.branch = 0; bus.jump_reg = 0; bus.ret = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_jr(input logic [31:0] tgt, input logic r);
    bus.jump_reg = 1; bus.ret = r; bus.jr_target = tgt;
    step();
  endtask

  task automatic do_jal(input logic [25:0] idx);
    bus.jump = 1; bus.link = 1; bus.jidx = idx;
    step();
  endtask

  logic [31:0] rets [4] = '{32'h48, 32'h38, 32'h28, 32'h18};

  initial begin
    idle_inputs();
    #2;
    check("rst_pc", bus.pc, 32'h0);
    check("rst_valid", {31'b0, bus.ras_valid}, 32'h0);
    check("rst_cnt", {16'b0, bus.mispredict_cnt}, 32'h0);
    check("rst_pulse", {31'b0, bus.ras_mispredict}, 32'h0);
    rst = 0;
    @(posedge clk); #1;
    check("seq_pc0", bus.pc, 32'h4);
    step(); check("seq_pc1", bus.pc, 32'h8);
    step(); check("seq_pc2", bus.pc, 32'hC);
    check("seq_p8", bus.pc_plus_8, 32'h14);

    // single call / matching return
    do_jr(32'h100, 0);
    check("jr_pc", bus.pc, 32'h100);
    do_jal(26'h40);
    check("jal_pc", bus.pc, 32'h100);
    check("jal_top", bus.ras_top, 32'h108);
    check("jal_valid", {31'b0, bus.ras_valid}, 32'h1);
    do_jr(32'h108, 1);
    check("ret_pc", bus.pc, 32'h108);
    check("ret_valid", {31'b0, bus.ras_valid}, 32'h0);
    check("ret_pulse", {31'b0, bus.ras_mispredict}, 32'h0);

    // five calls into a 4-deep stack
    for (int i = 0; i < 5; i++) begin
      do_jr(32'(i * 16), 0);
      do_jal(26'h0);
    end
    check("full_valid", {31'b0, bus.ras_valid}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("deep_top%0d", i), bus.ras_top, rets[i]);
      do_jr(rets[i], 1);
      check($sformatf("deep_pc%0d", i), bus.pc, rets[i]);
      check($sformatf("deep_pulse%0d", i), {31'b0, bus.ras_mispredict}, 32'h0);
    end
    check("deep_empty", {31'b0, bus.ras_valid}, 32'h0);
    check("deep_cnt", {16'b0, bus.mispredict_cnt}, 32'h0);

    // mispredicted return, then pop on empty
    do_jr(32'h200, 0);
    do_jal(26'h0);
    check("mp_top", bus.ras_top, 32'h208);
    do_jr(32'h300, 1);
    check("mp_pc", bus.pc, 32'h300);
    check("mp_pulse", {31'b0, bus.ras_mispredict}, 32'h1);
    check("mp_cnt", {16'b0, bus.mispredict_cnt}, 32'h1);
    step();
    check("mp_pulse_end", {31'b0, bus.ras_mispredict}, 32'h0);
    do_jr(32'h400, 1);
    check("empty_pc", bus.pc, 32'h400);
    check("empty_pulse", {31'b0, bus.ras_mispredict}, 32'h0);
    check("empty_cnt", {16'b0, bus.mispredict_cnt}, 32'h1);

    // stall and exception
    do_jr(32'h500, 0);
    bus.stall = 1; bus.branch = 1; bus.br_offset = 32'h40;
    step();
    check("stall_pc", bus.pc, 32'h500);
    bus.stall = 1; bus.jump = 1; bus.link = 1;
    step();
    check("stall_nopush", {31'b0, bus.ras_valid}, 32'h0);
    bus.stall = 1; bus.exc = 1; bus.jump = 1; bus.link = 1;
    step();
    check("exc_pc", bus.pc, 32'h8000_0180);
    check("exc_nopush", {31'b0, bus.ras_valid}, 32'h0);
    check("exc_cnt", {16'b0, bus.mispredict_cnt}, 32'h1);
    do_jr(32'h20, 0);
    bus.branch = 1; bus.br_offset = 32'hFFFF_FFF8;
    step();
    check("br_back", bus.pc, 32'h1C);
    bus.jump = 1; bus.jump_reg = 1; bus.ret = 1; bus.link = 1; bus.jidx = 26'h10;
    step();
    check("jmp_over_jr", bus.pc, 32'h40);
    check("jmp_over_jr_push", bus.ras_top, 32'h24);
    do_jr(32'h24, 1);

    // wrap at top of address space
    do_jr(32'hFFFF_FFFC, 0);
    step();
    check("wrap_pc", bus.pc, 32'h0);

    // asynchronous reset with two entries held and a push in flight
    do_jal(26'h0);
    do_jal(26'h0);
    check("pre_rst_valid", {31'b0, bus.ras_valid}, 32'h1);
    bus.jump = 1; bus.link = 1;
    #3 rst = 1;
    #1;
    check("arst_pc", bus.pc, 32'h0);
    check("arst_valid", {31'b0, bus.ras_valid}, 32'h0);
    check("arst_cnt", {16'b0, bus.mispredict_cnt}, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    rst = 0;
    check("arst_hold_pc", bus.pc, 32'h0);
    step();
    check("post_rst_pc", bus.pc, 32'h4);
    check("post_rst_valid", {31'b0, bus.ras_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
